// File: rtl/smmha_tcdm_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_intf_tcdm
// Brief    : Single TCDM request/response port between a streamer and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input  gnt, r_data, r_valid);
    modport slave  (input  req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface
`default_nettype wire

// File: rtl/smmha_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : smmha_tcdm_responder
// Brief    : MP-port round-robin TCDM slave memory with fixed read latency.
//            Define SMMHA_TCDM_RESP_STALL_EN for LFSR-driven grant stalls.
// Revision : 1.0 - initial release
// ============================================================================
module smmha_tcdm_responder #(
    parameter int MP    = 2,
    parameter int DEPTH = 1024,
    parameter int LAT   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hwpe_stream_intf_tcdm.slave   tcdm [MP],
    output logic [31:0]           n_rd_o,
    output logic [31:0]           n_wr_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = (MP > 1) ? $clog2(MP) : 1;

    logic [MP-1:0]   w_req;
    logic [MP-1:0]   w_wen;
    logic [c_AW-1:0] w_idx_p  [MP];
    logic [3:0]      w_be_p   [MP];
    logic [31:0]     w_data_p [MP];
    logic [MP-1:0]   w_gnt;
    logic [MP-1:0]   r_rvalid;
    logic [31:0]     r_rdata  [MP];

    for (genvar gp = 0; gp < MP; gp++) begin : g_port
        assign w_req[gp]          = tcdm[gp].req;
        assign w_wen[gp]          = tcdm[gp].wen;
        assign w_idx_p[gp]        = tcdm[gp].add[c_AW+1:2];
        assign w_be_p[gp]         = tcdm[gp].be;
        assign w_data_p[gp]       = tcdm[gp].data;
        assign tcdm[gp].gnt       = w_gnt[gp];
        assign tcdm[gp].r_valid   = r_rvalid[gp];
        assign tcdm[gp].r_data    = r_rdata[gp];
    end

    logic [c_PW-1:0] r_rr;
    logic [c_PW-1:0] w_sel;
    logic [c_PW:0]   w_scan;
    logic            w_any;
    logic            w_stall;
    logic            w_go;
    logic            w_rd_go;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_rd_word;
    logic [31:0]     r_n_rd;
    logic [31:0]     r_n_wr;
    logic [31:0]     r_mem [DEPTH];

    // Scan offsets from high to low so the lowest offset from rr wins.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = r_rr;
        w_scan = '0;
        for (int i = MP - 1; i >= 0; i--) begin
            w_scan = {1'b0, r_rr} + (c_PW+1)'(i);
            if (w_scan >= (c_PW+1)'(MP)) begin
                w_scan = w_scan - (c_PW+1)'(MP);
            end
            if (w_req[w_scan[c_PW-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_scan[c_PW-1:0];
            end
        end
    end

    assign w_go      = w_any && !w_stall && !rst_i;
    assign w_rd_go   = w_go && w_wen[w_sel];
    assign w_idx     = w_idx_p[w_sel];
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_gnt = '0;
        if (w_go) begin
            w_gnt[w_sel] = 1'b1;
        end
    end

`ifdef SMMHA_TCDM_RESP_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr   <= '0;
            r_n_rd <= '0;
            r_n_wr <= '0;
        end else if (w_go) begin
            r_rr <= (w_sel == c_PW'(MP - 1)) ? '0 : w_sel + 1'b1;
            if (w_wen[w_sel]) begin
                r_n_rd <= r_n_rd + 32'd1;
            end else begin
                r_n_wr <= r_n_wr + 32'd1;
            end
        end
    end

    assign n_rd_o = r_n_rd;
    assign n_wr_o = r_n_wr;

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk_i) begin
        if (w_go && !w_wen[w_sel]) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be_p[w_sel][b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_data_p[w_sel][8*b +: 8];
                end
            end
        end
    end

    logic            w_head_v;
    logic [c_PW-1:0] w_head_p;
    logic [31:0]     w_head_d;

    // The per-port output registers form the last latency stage.
    if (LAT <= 1) begin : g_lat_direct
        assign w_head_v = w_rd_go;
        assign w_head_p = w_sel;
        assign w_head_d = w_rd_word;
    end else begin : g_lat_pipe
        logic [LAT-2:0]  r_pv;
        logic [c_PW-1:0] r_pp [LAT-1];
        logic [31:0]     r_pd [LAT-1];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_pv <= '0;
                for (int s = 0; s < LAT - 1; s++) begin
                    r_pp[s] <= '0;
                    r_pd[s] <= '0;
                end
            end else begin
                r_pv[0] <= w_rd_go;
                r_pp[0] <= w_sel;
                r_pd[0] <= w_rd_word;
                for (int s = 1; s < LAT - 1; s++) begin
                    r_pv[s] <= r_pv[s-1];
                    r_pp[s] <= r_pp[s-1];
                    r_pd[s] <= r_pd[s-1];
                end
            end
        end

        assign w_head_v = r_pv[LAT-2];
        assign w_head_p = r_pp[LAT-2];
        assign w_head_d = r_pd[LAT-2];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            for (int p = 0; p < MP; p++) begin
                r_rdata[p] <= '0;
            end
        end else begin
            for (int p = 0; p < MP; p++) begin
                r_rvalid[p] <= w_head_v && (w_head_p == c_PW'(p));
                if (w_head_v && (w_head_p == c_PW'(p))) begin
                    r_rdata[p] <= w_head_d;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smmha_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_smmha_tcdm_responder
// Brief    : Randomized and directed bench for smmha_tcdm_responder against
//            a transaction-level memory/arbiter reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smmha_tcdm_responder;

    localparam int MP    = 2;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;
`ifdef SMMHA_TCDM_RESP_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct { bit wen; bit [31:0] add; bit [3:0] be; bit [31:0] data; } txn_t;
    typedef struct { int due; int port; bit [31:0] d; } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   n_rd;
    logic [31:0]   n_wr;
    logic [MP-1:0] req_d;
    logic [MP-1:0] wen_d;
    logic [31:0]   add_d   [MP];
    logic [3:0]    be_d    [MP];
    logic [31:0]   data_d  [MP];
    logic [MP-1:0] gnt_s;
    logic [MP-1:0] rvalid_s;
    logic [31:0]   rdata_s [MP];

    hwpe_stream_intf_tcdm tcdm_if [MP] ();

    for (genvar g = 0; g < MP; g++) begin : g_bind
        assign tcdm_if[g].req  = req_d[g];
        assign tcdm_if[g].wen  = wen_d[g];
        assign tcdm_if[g].add  = add_d[g];
        assign tcdm_if[g].be   = be_d[g];
        assign tcdm_if[g].data = data_d[g];
        assign gnt_s[g]        = tcdm_if[g].gnt;
        assign rvalid_s[g]     = tcdm_if[g].r_valid;
        assign rdata_s[g]      = tcdm_if[g].r_data;
    end

    smmha_tcdm_responder #(
        .MP    (MP),
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tcdm   (tcdm_if),
        .n_rd_o (n_rd),
        .n_wr_o (n_wr)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [31:0] mem_m [DEPTH];
    txn_t      q [MP][$];
    resp_t     resp_q [$];
    int        gnt_log [$];
    int        rr_m;
    int        cyc;
    int        nonstall;
    bit [31:0] nrd_m;
    bit [31:0] nwr_m;
    bit [15:0] lfsr_m;
    bit [31:0] exp_rdata [MP];
    bit [31:0] last_rd [MP];
    int        rv_cnt [MP];
    int        checks;
    int        errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit pending();
        bit any;
        any = 1'b0;
        for (int p = 0; p < MP; p++) begin
            if (q[p].size() > 0) any = 1'b1;
        end
        return any;
    endfunction

    // One clock: drive, predict/check grant, advance, check responses.
    task automatic step();
        int   g;
        int   w;
        bit   stall;
        bit   ev;
        txn_t t;
        for (int p = 0; p < MP; p++) begin
            if (q[p].size() > 0) begin
                req_d[p]  = 1'b1;
                wen_d[p]  = q[p][0].wen;
                add_d[p]  = q[p][0].add;
                be_d[p]   = q[p][0].be;
                data_d[p] = q[p][0].data;
            end else begin
                req_d[p]  = 1'b0;
                wen_d[p]  = 1'($urandom);
                add_d[p]  = $urandom;
                be_d[p]   = 4'($urandom);
                data_d[p] = $urandom;
            end
        end
        #1;
        stall = STALL_EN && (lfsr_m % 4 == 0);
        g = -1;
        if (!stall) begin
            for (int i = 0; i < MP; i++) begin
                if (g < 0 && q[(rr_m + i) % MP].size() > 0) g = (rr_m + i) % MP;
            end
            nonstall++;
        end
        for (int p = 0; p < MP; p++) begin
            chk($sformatf("gnt%0d", p), gnt_s[p], (g == p));
            if (gnt_s[p]) gnt_log.push_back(p);
        end
        if (g >= 0) begin
            t = q[g].pop_front();
            w = int'((t.add >> 2) % DEPTH);
            if (t.wen) begin
                resp_q.push_back('{cyc + LAT, g, mem_m[w]});
                nrd_m++;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (t.be[b]) mem_m[w][8*b +: 8] = t.data[8*b +: 8];
                end
                nwr_m++;
            end
            rr_m = (g + 1) % MP;
        end
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        @(posedge clk);
        cyc++;
        #1;
        for (int p = 0; p < MP; p++) begin
            ev = 1'b0;
            if (resp_q.size() > 0 && resp_q[0].due == cyc && resp_q[0].port == p) begin
                ev = 1'b1;
                exp_rdata[p] = resp_q[0].d;
                resp_q.delete(0);
            end
            chk($sformatf("r_valid%0d", p), rvalid_s[p], ev);
            chk($sformatf("r_data%0d", p), rdata_s[p], exp_rdata[p]);
            if (rvalid_s[p]) begin
                last_rd[p] = rdata_s[p];
                rv_cnt[p]++;
            end
        end
        chk("n_rd", n_rd, nrd_m);
        chk("n_wr", n_wr, nwr_m);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int p = 0; p < MP; p++) begin
            req_d[p] = 1'b1;
            q[p].delete();
            exp_rdata[p] = '0;
        end
        resp_q.delete();
        rr_m   = 0;
        nrd_m  = '0;
        nwr_m  = '0;
        lfsr_m = 16'hACE1;
        #1;
        for (int p = 0; p < MP; p++) begin
            chk($sformatf("rst_gnt%0d", p), gnt_s[p], 1'b0);
            chk($sformatf("rst_r_valid%0d", p), rvalid_s[p], 1'b0);
            chk($sformatf("rst_r_data%0d", p), rdata_s[p], 32'h0);
        end
        chk("rst_n_rd", n_rd, 32'h0);
        chk("rst_n_wr", n_wr, 32'h0);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
        for (int p = 0; p < MP; p++) req_d[p] = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (pending() && b < 500) begin
            step();
            b++;
        end
        chk("drain_bound", (b < 500), 1'b1);
        repeat (LAT + 1) step();
    endtask

    initial begin
        rst = 1'b0;
        checks = 0;
        errors = 0;
        cyc = 0;
        nonstall = 0;
        for (int p = 0; p < MP; p++) begin
            req_d[p] = 1'b0; wen_d[p] = 1'b0; add_d[p] = '0; be_d[p] = '0; data_d[p] = '0;
            last_rd[p] = '0; rv_cnt[p] = 0;
        end
        #1;
        do_reset(2);

        // Preload the working set so every later read has a defined value.
        for (int w = 0; w < 64; w++) begin
            q[w % MP].push_back('{1'b0, 32'(w * 4), 4'hF, 32'($urandom)});
        end
        drain();

        // Round-robin with both ports reading from reset
        do_reset(2);
        gnt_log.delete();
        for (int p = 0; p < MP; p++) rv_cnt[p] = 0;
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < MP; p++) q[p].push_back('{1'b1, 32'(($urandom % 64) * 4), 4'hF, 32'h0});
        end
        drain();
        chk("rr_len", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk($sformatf("rr_seq%0d", i), gnt_log[i], i % 2);
        chk("rr_pulses0", rv_cnt[0], 3);
        chk("rr_pulses1", rv_cnt[1], 3);

        // Single write then read
        do_reset(1);
        q[0].push_back('{1'b0, 32'h40, 4'hF, 32'hDEADBEEF});
        q[0].push_back('{1'b1, 32'h40, 4'hF, 32'h0});
        drain();
        chk("wr_rd_data", last_rd[0], 32'hDEADBEEF);
        chk("wr_rd_n_wr", n_wr, 32'd1);
        chk("wr_rd_n_rd", n_rd, 32'd1);

        // Byte enables
        q[1].push_back('{1'b0, 32'h80, 4'hF, 32'h11223344});
        q[1].push_back('{1'b0, 32'h80, 4'b0101, 32'hAABBCCDD});
        q[1].push_back('{1'b1, 32'h80, 4'h0, 32'h0});
        drain();
        chk("be_data", last_rd[1], 32'h11BB33DD);

        // Address wrap modulo DEPTH
        q[0].push_back('{1'b0, 32'h1000, 4'hF, 32'h5A5A5A5A});
        q[0].push_back('{1'b1, 32'h0000, 4'hF, 32'h0});
        drain();
        chk("wrap_data", last_rd[0], 32'h5A5A5A5A);

        // Randomized traffic, with upper and lower address bits scrambled
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < MP; p++) begin
                if (q[p].size() == 0 && ($urandom % 4) != 0) begin
                    q[p].push_back('{1'($urandom),
                                     ($urandom & 32'hFFFF_F000) | 32'(($urandom % 64) << 2) | 32'($urandom % 4),
                                     4'($urandom), $urandom});
                end
            end
            step();
        end
        drain();

        // Reset while a read is in flight
        q[0].push_back('{1'b1, 32'h40, 4'hF, 32'h0});
        begin
            int b;
            b = 0;
            while (pending() && b < 100) begin
                step();
                b++;
            end
            chk("midrst_grant_bound", (b < 100), 1'b1);
        end
        step();
        for (int p = 0; p < MP; p++) rv_cnt[p] = 0;
        do_reset(2);
        repeat (LAT + 5) step();
        chk("midrst_pulses0", rv_cnt[0], 0);
        chk("midrst_n_rd", n_rd, 32'd0);
        chk("midrst_n_wr", n_wr, 32'd0);

        // Continuous single-port requests; stalls follow the reference LFSR
        do_reset(1);
        nonstall = 0;
        for (int i = 0; i < 80; i++) q[0].push_back('{1'b1, 32'(($urandom % 64) * 4), 4'hF, 32'h0});
        repeat (64) step();
        chk("stall_n_rd", n_rd, 32'(nonstall));
        q[0].delete();
        repeat (LAT + 1) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smmha_tcdm_responder.md
# smmha_tcdm_responder

TCDM slave model/memory that serves the `hwpe_stream_intf_tcdm` master ports driven by the smmha accelerator streamer. It arbitrates `MP` request ports onto one single-port word array with round-robin fairness. It returns read data after a fixed latency. It sits on the memory side of the accelerator in block-level integration and in the standalone testbench, in place of the cluster TCDM interconnect.

## Interface
- `MP`, 2: number of TCDM slave ports.
- `DEPTH`, 1024: memory size in 32-bit words; power of two.
- `LAT`, 1: read latency in cycles from grant to `r_valid`; legal range 1..4.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `tcdm`  slave  `MP` x `hwpe_stream_intf_tcdm`  request ports. Fields: `req`, `gnt`, `add[31:0]`, `wen` (1=read, 0=write), `be[3:0]`, `data[31:0]`, `r_data[31:0]`, `r_valid`.
- `n_rd_o`  out  32  count of granted reads since reset.
- `n_wr_o`  out  32  count of granted writes since reset.

## Operation
- Word index is `add[$clog2(DEPTH)+1:2]`. Upper bits are ignored, so addresses wrap modulo DEPTH. `add[1:0]` is ignored.
- Arbitration: at most one grant per cycle across all ports.
  - Round-robin pointer `rr` resets to 0.
  - The granted port is the first requesting port at or after `rr`, scanning upward with wrap.
  - After a grant to port k, `rr` becomes (k+1) mod MP.
  - With no grant, `rr` holds.
- `gnt` is combinational from `req`, `rr` and stall state, in the same cycle as `req`. Non-granted requesters see `gnt`=0 and must hold the request.
- Write (granted, `wen`=0): byte lanes with `be[i]`=1 are updated at the clock edge. `be`=4'b0000 is a legal no-op, but it still counts as a write.
- Read (granted, `wen`=1): the word is sampled at the grant edge and shifted through a LAT-deep pipeline tagged with the port index. That port's `r_valid` is high for exactly one cycle, LAT cycles after the grant, with `r_data` set. `r_data` holds its last value when `r_valid`=0.
- Read-after-write: a read granted in the cycle after a write to the same word returns the new data.
- Counters increment on each granted access. They wrap at 2^32.
- Memory contents are not affected by reset.

## Timing
- Reset values: all `gnt`=0 while `rst_i`=1; all `r_valid`=0; all `r_data`=0; `n_rd_o`=0; `n_wr_o`=0; `rr`=0; read pipeline empty.
- Reset mid-operation clears the pipeline asynchronously. In-flight reads are discarded, and no `r_valid` appears after reset releases.
- Throughput: one access per cycle in aggregate. With all MP ports requesting continuously, each port gets one grant every MP cycles.
- Read latency is exactly LAT cycles. Back-to-back reads from one port return in grant order, on consecutive cycles.
- A write and a pipelined read response can occur in the same cycle; they are independent.

## Configuration
- `SMMHA_TCDM_RESP_STALL_EN` defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - When `lfsr[1:0]`==2'b00, no grant is issued that cycle, and `rr` and the counters hold.
  - Pending read responses are unaffected.
- `SMMHA_TCDM_RESP_STALL_EN` undefined: no LFSR is present, and any requesting port is granted every cycle per round-robin.

## Test plan
- Single write then read: port 0 writes 0xDEADBEEF to 0x40 with `be`=4'hF, then reads 0x40. Required: `gnt` in the same cycle as `req`; `r_valid` LAT cycles after the read grant with `r_data`=0xDEADBEEF; `n_wr_o`=1; `n_rd_o`=1.
- Byte enables: write 0x11223344, then write 0xAABBCCDD with `be`=4'b0101, then read. Required: `r_data`=0x11BB33DD.
- Round-robin: both ports (MP=2) request reads continuously for 6 cycles from reset. Required grant sequence is 0,1,0,1,0,1, and each port receives 3 `r_valid` pulses.
- Address wrap: with DEPTH=1024, write 0x5A5A5A5A to 0x1000, then read 0x0000. Required: `r_data`=0x5A5A5A5A.
- Reset mid-read: with LAT=3, grant a read, then assert `rst_i` one cycle later for 2 cycles. Required: no `r_valid` at any time afterwards; both counters read 0.
- Stall build (`SMMHA_TCDM_RESP_STALL_EN` defined): port 0 requests continuously for 64 cycles. Required: grants drop exactly on cycles with `lfsr[1:0]`==0, checked against a reference LFSR, and `n_rd_o` equals the number of non-stall cycles.
